// File: rtl/semafor_secvential_if.sv
// Command/lamp bundle for semafor_secvential. The cerere request vector exists
// only when SEMAFOR_CERERE_EN is defined.
interface semafor_secvential_if #(
  parameter int NCH = 4
);
  localparam int CW = $clog2(NCH);

  logic          intretinere;
  logic          start;
`ifdef SEMAFOR_CERERE_EN
  logic [NCH-1:0] cerere;
`endif
  logic          ocupat;
  logic          continuare;
  logic [CW-1:0] canal;
  logic [NCH-1:0] verde;
  logic [NCH-1:0] galben;
  logic [NCH-1:0] rosu;

`ifdef SEMAFOR_CERERE_EN
  modport master (output intretinere, start, cerere,
                  input  ocupat, continuare, canal, verde, galben, rosu);
  modport slave  (input  intretinere, start, cerere,
                  output ocupat, continuare, canal, verde, galben, rosu);
`else
  modport master (output intretinere, start,
                  input  ocupat, continuare, canal, verde, galben, rosu);
  modport slave  (input  intretinere, start,
                  output ocupat, continuare, canal, verde, galben, rosu);
`endif
endinterface

// File: rtl/semafor_secvential.sv
// Sequential traffic-light controller: serves NCH approaches in turn (CLR/GALBEN/VERDE).
// Define SEMAFOR_CERERE_EN to serve only channels flagged in cerere at start.
//
// state  | meaning
// IDLE   | waiting for start, all red
// CLR    | all-red clearance before the served channel
// GALBEN | served channel yellow
// VERDE  | served channel green
// DONE   | one-cycle continuare pulse, then IDLE
// MAINT  | maintenance: all yellow blinking on tick, no red/green
module semafor_secvential #(
  parameter int SEC      = 10000000,
  parameter int NCH      = 4,
  parameter int T_CLR    = 1,
  parameter int T_GALBEN = 2,
  parameter int T_VERDE  = 15
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  semafor_secvential_if.slave  io_bus
);
  localparam int CW   = $clog2(NCH);
  localparam int PSW  = (SEC > 1) ? $clog2(SEC) : 1;
  localparam int TMAX = (T_CLR > T_GALBEN) ? ((T_CLR > T_VERDE) ? T_CLR : T_VERDE)
                                           : ((T_GALBEN > T_VERDE) ? T_GALBEN : T_VERDE);
  localparam int PW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_GALBEN, S_VERDE, S_DONE, S_MAINT} state_t;

  state_t          r_state, w_state_nxt;
  logic [PSW-1:0]  r_pre;
  logic [PW-1:0]   r_phase;
  logic [CW-1:0]   r_canal, w_canal_nxt;
  logic            r_blink;
  logic            w_tick;
  logic            w_expire;
  logic            w_first_vld, w_next_vld;
  logic [CW-1:0]   w_first_idx, w_next_idx;
  logic [NCH-1:0]  w_verde, w_galben, w_rosu;

  assign w_tick = (r_pre == PSW'(SEC - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)    r_pre <= '0;
    else if (w_tick) r_pre <= '0;
    else             r_pre <= r_pre + PSW'(1);
  end

  // A state lasting T ticks leaves on the tick that would bring the count to T.
  always_comb begin
    w_expire = 1'b0;
    case (r_state)
      S_CLR:    w_expire = w_tick && (r_phase == PW'(T_CLR - 1));
      S_GALBEN: w_expire = w_tick && (r_phase == PW'(T_GALBEN - 1));
      S_VERDE:  w_expire = w_tick && (r_phase == PW'(T_VERDE - 1));
      default:  w_expire = 1'b0;
    endcase
  end

`ifdef SEMAFOR_CERERE_EN
  logic [NCH-1:0] r_cerere;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      r_cerere <= '0;
    else if (r_state == S_IDLE && io_bus.start && !io_bus.intretinere)
      r_cerere <= io_bus.cerere;
  end

  // Lowest requested index overall, and lowest requested index above canal.
  always_comb begin
    w_first_vld = 1'b0;
    w_first_idx = '0;
    w_next_vld  = 1'b0;
    w_next_idx  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (io_bus.cerere[i]) begin
        w_first_vld = 1'b1;
        w_first_idx = CW'(i);
      end
      if (r_cerere[i] && (CW'(i) > r_canal)) begin
        w_next_vld = 1'b1;
        w_next_idx = CW'(i);
      end
    end
  end
`else
  assign w_first_vld = 1'b1;
  assign w_first_idx = '0;
  assign w_next_vld  = (r_canal != CW'(NCH - 1));
  assign w_next_idx  = r_canal + CW'(1);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_canal_nxt = r_canal;
    if (io_bus.intretinere) begin
      w_state_nxt = S_MAINT;
    end else begin
      case (r_state)
        S_IDLE:
          if (io_bus.start) begin
            if (w_first_vld) begin
              w_state_nxt = S_CLR;
              w_canal_nxt = w_first_idx;
            end else begin
              w_state_nxt = S_DONE;
              w_canal_nxt = '0;
            end
          end
        S_CLR:    if (w_expire) w_state_nxt = S_GALBEN;
        S_GALBEN: if (w_expire) w_state_nxt = S_VERDE;
        S_VERDE:
          if (w_expire) begin
            if (w_next_vld) begin
              w_state_nxt = S_CLR;
              w_canal_nxt = w_next_idx;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        default: begin
          w_state_nxt = S_IDLE;
          w_canal_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_canal <= '0;
      r_phase <= '0;
      r_blink <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_canal <= w_canal_nxt;
      if (w_state_nxt != r_state) r_phase <= '0;
      else if (w_tick)            r_phase <= r_phase + PW'(1);
      if (w_state_nxt == S_MAINT && r_state != S_MAINT) r_blink <= 1'b1;
      else if (r_state == S_MAINT && w_tick)            r_blink <= ~r_blink;
    end
  end

  always_comb begin
    w_verde  = '0;
    w_galben = '0;
    w_rosu   = '1;
    case (r_state)
      S_GALBEN: begin
        w_galben[r_canal] = 1'b1;
        w_rosu[r_canal]   = 1'b0;
      end
      S_VERDE: begin
        w_verde[r_canal] = 1'b1;
        w_rosu[r_canal]  = 1'b0;
      end
      S_MAINT: begin
        w_rosu   = '0;
        w_galben = {NCH{r_blink}};
      end
      default: ;
    endcase
  end

  assign io_bus.verde      = w_verde;
  assign io_bus.galben     = w_galben;
  assign io_bus.rosu       = w_rosu;
  assign io_bus.canal      = r_canal;
  assign io_bus.ocupat     = (r_state == S_CLR) || (r_state == S_GALBEN) || (r_state == S_VERDE);
  assign io_bus.continuare = (r_state == S_DONE);
endmodule
